// File: rtl/rv_core_mc.sv
// rv_core_mc: multi-cycle RV32I core executing OP-IMM and OP ALU groups.
// Ports: clk/rst_n, last_pc halt address, instr_req/instr_ack/instr fetch
// port with instr_addr=pc, retire/illegal pulses, halted level, and a
// combinational debug register read (dbg_rd_addr -> dbg_rd_data).
module rv_core_mc #(
  parameter int          XLEN     = 32,
  parameter int          NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     last_pc,
  output logic            instr_req,
  output logic [31:0]     instr_addr,
  input  logic            instr_ack,
  input  logic [31:0]     instr,
  output logic            retire,
  output logic            illegal,
  output logic            halted,
  input  logic [4:0]      dbg_rd_addr,
  output logic [XLEN-1:0] dbg_rd_data
);

  localparam int AW = $clog2(NREGS);
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    WB,
    HALT
  } state_t;

  typedef struct packed {
    logic [6:0] f7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [6:0] opc;
  } rtype_t;

  state_t          state;
  logic [31:0]     pc;
  rtype_t          ir;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] rf [NREGS];

  logic            is_imm;
  logic            is_reg;
  logic            f7_base;
  logic            f7_alt;
  logic            idx_bad;
  logic            legal;
  logic            lt_s;
  logic            lt_u;
  logic            we;
  logic [4:0]      shamt;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_v;
  logic [XLEN-1:0] rs2_v;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] alu;

  assign instr_addr = pc;

  assign is_imm  = (ir.opc == OP_IMM);
  assign is_reg  = (ir.opc == OP_REG);
  assign f7_base = (ir.f7 == F7_BASE);
  assign f7_alt  = (ir.f7 == F7_ALT);

  // Register indices wider than the file (RV32E) make the op illegal.
  // For OP-IMM the rs2 field is immediate bits, so it is not checked.
  assign idx_bad = (NREGS < 32) &&
                   (ir.rd[4] | ir.rs1[4] | (is_reg & ir.rs2[4]));

  assign imm   = {{(XLEN-12){ir.f7[6]}}, ir.f7, ir.rs2};
  assign rs1_v = rf[ir.rs1[AW-1:0]];
  assign rs2_v = rf[ir.rs2[AW-1:0]];
  assign opb   = is_reg ? rs2_v : imm;
  assign shamt = is_reg ? rs2_v[4:0] : ir.rs2;
  assign lt_s  = $signed(rs1_v) < $signed(opb);
  assign lt_u  = rs1_v < opb;

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      is_imm: begin
        legal = 1'b1;
        if (ir.f3 == 3'b001)
          legal = f7_base;
        if (ir.f3 == 3'b101)
          legal = f7_base | f7_alt;
      end
      is_reg: begin
        legal = f7_base |
                (f7_alt & (ir.f3 == 3'b000 ||
                           ir.f3 == 3'b101));
      end
      default: legal = 1'b0;
    endcase
    if (idx_bad)
      legal = 1'b0;
  end

  // The funct3 datapath is shared by both groups; legality above
  // filters out encodings whose funct7 does not fit.
  always_comb begin
    alu = '0;
    case (ir.f3)
      3'b000: begin
        if (is_reg & f7_alt)
          alu = rs1_v - opb;
        else
          alu = rs1_v + opb;
      end
      3'b001: alu = rs1_v << shamt;
      3'b010: alu = {{(XLEN-1){1'b0}}, lt_s};
      3'b011: alu = {{(XLEN-1){1'b0}}, lt_u};
      3'b100: alu = rs1_v ^ opb;
      3'b101: begin
        if (f7_alt)
          alu = XLEN'($signed(rs1_v) >>> shamt);
        else
          alu = rs1_v >> shamt;
      end
      3'b110: alu = rs1_v | opb;
      3'b111: alu = rs1_v & opb;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      result    <= '0;
      instr_req <= 1'b0;
      retire    <= 1'b0;
      illegal   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      retire  <= 1'b0;
      illegal <= 1'b0;
      unique case (state)
        FETCH: begin
          // After reset the request comes up one cycle late;
          // afterwards WB raises it on the way back here.
          if (!instr_req) begin
            instr_req <= 1'b1;
          end else if (instr_ack) begin
            ir        <= rtype_t'(instr);
            instr_req <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          result  <= alu;
          retire  <= 1'b1;
          illegal <= ~legal;
          state   <= WB;
        end
        WB: begin
          if (pc == last_pc) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            pc        <= pc + 32'(PC_STEP);
            instr_req <= 1'b1;
            state     <= FETCH;
          end
        end
        HALT: begin
          instr_req <= 1'b0;
          halted    <= 1'b1;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // illegal is held for the whole WB cycle, so it gates the write.
  assign we = (state == WB) && !illegal && (ir.rd != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        rf[i] <= '0;
    end else if (we) begin
      rf[ir.rd[AW-1:0]] <= result;
    end
  end

  assign dbg_rd_data = (dbg_rd_addr == 5'd0) ? '0 :
                       rf[dbg_rd_addr[AW-1:0]];

endmodule

// File: tb/tb_rv_core_mc.sv
// tb_rv_core_mc: randomized bench for rv_core_mc against a mnemonic model.
// Two instances: RV32I step 4, and RV32E (NREGS=16) step 16.
module tb_rv_core_mc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] last_pc = 32'h0;
  logic        ack_v = 1'b0;
  logic [31:0] instr_v = 32'h0;
  logic [4:0]  dbg_a = 5'd0;
  logic        sel = 1'b0;

  logic        req_a, ret_a, ill_a, halt_a;
  logic        req_b, ret_b, ill_b, halt_b;
  logic [31:0] addr_a, addr_b, dd_a, dd_b;
  logic        ack_a, ack_b;

  logic        req_s, ret_s, ill_s, halt_s;
  logic [31:0] addr_s, dd_s;

  assign ack_a  = ack_v & ~sel;
  assign ack_b  = ack_v & sel;
  assign req_s  = sel ? req_b : req_a;
  assign ret_s  = sel ? ret_b : ret_a;
  assign ill_s  = sel ? ill_b : ill_a;
  assign halt_s = sel ? halt_b : halt_a;
  assign addr_s = sel ? addr_b : addr_a;
  assign dd_s   = sel ? dd_b : dd_a;

  always #5 clk = ~clk;

  rv_core_mc #(
    .XLEN(32), .NREGS(32), .RESET_PC(32'h0), .PC_STEP(4)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .last_pc(last_pc),
    .instr_req(req_a), .instr_addr(addr_a),
    .instr_ack(ack_a), .instr(instr_v),
    .retire(ret_a), .illegal(ill_a), .halted(halt_a),
    .dbg_rd_addr(dbg_a), .dbg_rd_data(dd_a)
  );

  rv_core_mc #(
    .XLEN(32), .NREGS(16), .RESET_PC(32'h0), .PC_STEP(16)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .last_pc(last_pc),
    .instr_req(req_b), .instr_addr(addr_b),
    .instr_ack(ack_b), .instr(instr_v),
    .retire(ret_b), .illegal(ill_b), .halted(halt_b),
    .dbg_rd_addr(dbg_a), .dbg_rd_data(dd_b)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [int unsigned];
  int unsigned fetch_q[$];
  int unsigned exp_fetch[$];
  int          ret_cyc[$];
  int          ret_cnt, ill_cnt, exp_ret, exp_ill;
  logic [31:0] mregs [32];

  function automatic logic [31:0] enc_i(input logic [2:0] f3,
    input logic [4:0] rd, input logic [4:0] rs1,
    input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] rand_instr(input int rmax);
    int k;
    logic [4:0] rd, r1, r2;
    logic [11:0] imm;
    logic [31:0] w;
    k   = $urandom_range(0, 20);
    rd  = 5'($urandom_range(0, rmax));
    r1  = 5'($urandom_range(0, rmax));
    r2  = 5'($urandom_range(0, rmax));
    imm = 12'($urandom);
    w   = $urandom;
    case (k)
      0: return enc_i(3'd0, rd, r1, imm);
      1: return enc_i(3'd2, rd, r1, imm);
      2: return enc_i(3'd3, rd, r1, imm);
      3: return enc_i(3'd4, rd, r1, imm);
      4: return enc_i(3'd6, rd, r1, imm);
      5: return enc_i(3'd7, rd, r1, imm);
      6: return enc_i(3'd1, rd, r1, {7'h00, imm[4:0]});
      7: return enc_i(3'd5, rd, r1, {7'h00, imm[4:0]});
      8: return enc_i(3'd5, rd, r1, {7'h20, imm[4:0]});
      17: return enc_r(7'h20, 3'd0, rd, r1, r2);
      18: return enc_r(7'h20, 3'd5, rd, r1, r2);
      19: return {w[31:7], 7'h33};
      20: return (w[0] ? {w[31:7], 7'h13} : w);
      default: return enc_r(7'h00, 3'(k - 9), rd, r1, r2);
    endcase
  endfunction

  // Reference semantics: name the operation, then evaluate it with
  // plain integer arithmetic on the architectural register array.
  function automatic void model_exec(input logic [31:0] ins,
    input bit e16, output bit ok, output logic [4:0] rd,
    output logic [31:0] val);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] a, b, p2;
    int unsigned sh;
    string       mn;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    rd = ins[11:7];
    a  = mregs[ins[19:15]];
    b  = (op == 7'h33) ? mregs[ins[24:20]] :
                         {{20{ins[31]}}, ins[31:20]};
    sh = (op == 7'h33) ? b % 32 : ins[24:20];
    mn = "";
    if (op == 7'h13) begin
      case (f3)
        0: mn = "add";
        1: mn = (f7 == 0) ? "sll" : "";
        2: mn = "slt";
        3: mn = "sltu";
        4: mn = "xor";
        5: mn = (f7 == 0) ? "srl" :
                (f7 == 7'h20) ? "sra" : "";
        6: mn = "or";
        7: mn = "and";
        default: mn = "";
      endcase
    end else if (op == 7'h33 && f7 == 0) begin
      case (f3)
        0: mn = "add";
        1: mn = "sll";
        2: mn = "slt";
        3: mn = "sltu";
        4: mn = "xor";
        5: mn = "srl";
        6: mn = "or";
        7: mn = "and";
        default: mn = "";
      endcase
    end else if (op == 7'h33 && f7 == 7'h20) begin
      if (f3 == 0) mn = "sub";
      if (f3 == 5) mn = "sra";
    end
    if (e16 && (ins[11] || ins[19] ||
               (op == 7'h33 && ins[24])))
      mn = "";
    ok  = (mn != "");
    p2  = 32'd1 << sh;
    val = 32'h0;
    case (mn)
      "add":  val = 32'(longint'(a) + longint'(b));
      "sub":  val = 32'(longint'(a) - longint'(b));
      "slt":  val = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      "sltu": val = (a < b) ? 32'd1 : 32'd0;
      "xor":  val = a ^ b;
      "or":   val = a | b;
      "and":  val = a & b;
      "sll":  val = 32'(longint'(a) * longint'(p2));
      "srl":  val = a / p2;
      "sra":  val = a[31] ? ~((~a) / p2) : a / p2;
      default: val = 32'h0;
    endcase
  endfunction

  task automatic model_run(input int step, input bit e16);
    logic [31:0] pc, ins, val;
    logic [4:0]  rd;
    bit          ok;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    exp_fetch.delete();
    exp_ret = 0;
    exp_ill = 0;
    pc = 32'h0;
    for (int n = 0; n < 1000; n++) begin
      ins = mem.exists(pc) ? mem[pc] : NOP;
      exp_fetch.push_back(pc);
      model_exec(ins, e16, ok, rd, val);
      exp_ret++;
      if (!ok) exp_ill++;
      else if (rd != 0) mregs[rd] = val;
      if (pc == last_pc) break;
      pc = pc + 32'(step);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    ack_v   = 1'b0;
    instr_v = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_q.delete();
    ret_cyc.delete();
    ret_cnt = 0;
    ill_cnt = 0;
  endtask

  task automatic read_reg(input int i, output logic [31:0] v);
    dbg_a = 5'(i);
    #1;
    v = dd_s;
  endtask

  // Memory responder: answers each request after wmode wait cycles
  // (random 0..3 when negative) and optionally fires stray acks
  // while no request is pending.
  task automatic run_prog(input int wmode, input bit spur);
    int wleft;
    bit pend, done;
    wleft = 0;
    pend  = 0;
    done  = 0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (pend) begin
        checks++;
        if (req_s !== 1'b1) begin
          errors++;
          $display("FAIL req_held req=%b want 1", req_s);
        end
      end
      if (halt_s === 1'b1) begin
        done = 1;
      end else begin
        if (ret_s === 1'b1) begin
          ret_cnt++;
          ret_cyc.push_back(cyc);
        end
        if (ill_s === 1'b1) begin
          ill_cnt++;
          checks++;
          if (ret_s !== 1'b1) begin
            errors++;
            $display("FAIL ill_with_retire retire=%b want 1",
                     ret_s);
          end
        end
        ack_v = 1'b0;
        if (req_s === 1'b1) begin
          if (!pend) begin
            pend  = 1;
            wleft = (wmode < 0) ? $urandom_range(0, 3) : wmode;
          end
          if (wleft == 0) begin
            ack_v   = 1'b1;
            instr_v = mem.exists(addr_s) ? mem[addr_s] : NOP;
            fetch_q.push_back(addr_s);
            pend = 0;
          end else begin
            wleft--;
          end
        end else if (spur && $urandom_range(0, 1) == 1) begin
          ack_v   = 1'b1;
          instr_v = 32'hFFFF_FFFF;
        end
      end
    end
    ack_v = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL run_timeout halted=%b want 1", halt_s);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    sel   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_s, ret_s, ill_s, halt_s} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs req/ret/ill/halt=%b want 0000",
               {req_s, ret_s, ill_s, halt_s});
    end
    checks++;
    if (addr_s !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc addr=%h want 0", addr_s);
    end
    read_reg(5, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL reset_reg x5=%h want 0", v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_s !== 1'b0) begin
      errors++;
      $display("FAIL req_early req=%b want 0", req_s);
    end
    @(posedge clk);
    #1;
    checks++;
    if (req_s !== 1'b1) begin
      errors++;
      $display("FAIL req_rise req=%b want 1", req_s);
    end
  endtask

  task automatic test_addi();
    logic [31:0] v1, v2;
    int gap;
    sel = 1'b0;
    mem.delete();
    mem[0] = enc_i(3'd0, 5'd1, 5'd0, 12'd5);
    mem[4] = enc_i(3'd0, 5'd2, 5'd1, 12'hFFF);
    last_pc = 32'd4;
    do_reset();
    run_prog(0, 0);
    read_reg(1, v1);
    read_reg(2, v2);
    checks++;
    if (v1 !== 32'd5 || v2 !== 32'd4) begin
      errors++;
      $display("FAIL addi x1=%h x2=%h want 5 4", v1, v2);
    end
    checks++;
    if (ret_cnt != 2 || halt_s !== 1'b1) begin
      errors++;
      $display("FAIL addi_retire n=%0d halt=%b want 2 1",
               ret_cnt, halt_s);
    end
    gap = (ret_cyc.size() == 2) ? ret_cyc[1] - ret_cyc[0] : -1;
    checks++;
    if (gap != 3) begin
      errors++;
      $display("FAIL latency gap=%0d want 3", gap);
    end
  endtask

  task automatic test_shift();
    logic [31:0] v2, v3, v4;
    sel = 1'b0;
    mem.delete();
    mem[0]  = enc_i(3'd0, 5'd1, 5'd0, 12'hFF8);
    mem[4]  = enc_i(3'd5, 5'd2, 5'd1, {7'h20, 5'd1});
    mem[8]  = enc_i(3'd5, 5'd3, 5'd1, {7'h00, 5'd28});
    mem[12] = enc_i(3'd1, 5'd4, 5'd1, {7'h00, 5'd31});
    last_pc = 32'd12;
    do_reset();
    run_prog(-1, 1);
    read_reg(2, v2);
    read_reg(3, v3);
    read_reg(4, v4);
    checks++;
    if (v2 !== 32'hFFFF_FFFC || v3 !== 32'hF) begin
      errors++;
      $display("FAIL shift x2=%h x3=%h want fffffffc f", v2, v3);
    end
    checks++;
    if (v4 !== 32'h0) begin
      errors++;
      $display("FAIL slli31 x4=%h want 0", v4);
    end
  endtask

  task automatic test_slt();
    logic [31:0] v3, v4, v5;
    sel = 1'b0;
    mem.delete();
    mem[0]  = enc_i(3'd0, 5'd1, 5'd0, 12'hFFF);
    mem[4]  = enc_i(3'd0, 5'd2, 5'd0, 12'd1);
    mem[8]  = enc_r(7'h00, 3'd2, 5'd3, 5'd1, 5'd2);
    mem[12] = enc_r(7'h00, 3'd3, 5'd4, 5'd1, 5'd2);
    mem[16] = enc_r(7'h20, 3'd0, 5'd5, 5'd2, 5'd1);
    last_pc = 32'd16;
    do_reset();
    run_prog(0, 0);
    read_reg(3, v3);
    read_reg(4, v4);
    read_reg(5, v5);
    checks++;
    if (v3 !== 32'd1 || v4 !== 32'd0 || v5 !== 32'd2) begin
      errors++;
      $display("FAIL slt x3=%h x4=%h x5=%h want 1 0 2",
               v3, v4, v5);
    end
  endtask

  task automatic test_wait();
    logic [31:0] v0;
    sel = 1'b0;
    mem.delete();
    mem[0]  = enc_i(3'd0, 5'd0, 5'd0, 12'd7);
    last_pc = 32'd0;
    do_reset();
    run_prog(5, 1);
    read_reg(0, v0);
    checks++;
    if (ret_cnt != 1 || fetch_q.size() != 1) begin
      errors++;
      $display("FAIL wait_once ret=%0d fetch=%0d want 1 1",
               ret_cnt, fetch_q.size());
    end
    checks++;
    if (v0 !== 32'h0 || ill_cnt != 0) begin
      errors++;
      $display("FAIL x0_write x0=%h ill=%0d want 0 0", v0, ill_cnt);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    sel = 1'b0;
    mem.delete();
    mem[0]  = enc_i(3'd0, 5'd1, 5'd0, 12'd3);
    mem[4]  = enc_i(3'd0, 5'd2, 5'd0, 12'd4);
    mem[8]  = 32'hFFFF_FFFF;
    mem[12] = enc_i(3'd4, 5'd3, 5'd1, 12'd6);
    last_pc = 32'd12;
    do_reset();
    run_prog(-1, 0);
    model_run(4, 0);
    checks++;
    if (ill_cnt != 1 || ret_cnt != 4) begin
      errors++;
      $display("FAIL illegal ill=%0d ret=%0d want 1 4",
               ill_cnt, ret_cnt);
    end
    checks++;
    if (fetch_q.size() != 4 || fetch_q[3] != 12) begin
      errors++;
      $display("FAIL ill_next n=%0d want 4 with last addr 12",
               fetch_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      read_reg(i, v);
      checks++;
      if (v !== mregs[i]) begin
        errors++;
        $display("FAIL ill_reg x%0d=%h want %h", i, v, mregs[i]);
      end
    end
  endtask

  task automatic test_random(input bit e16, input int iters);
    logic [31:0] v;
    int n, step, nr;
    step = e16 ? 16 : 4;
    nr   = e16 ? 16 : 32;
    sel  = e16;
    for (int it = 0; it < iters; it++) begin
      n = $urandom_range(8, 24);
      mem.delete();
      for (int j = 0; j < n; j++)
        mem[j * step] = rand_instr(e16 ? 20 : 7);
      last_pc = 32'((n - 1) * step);
      do_reset();
      run_prog(-1, 1);
      model_run(step, e16);
      checks++;
      if (ret_cnt != exp_ret || ill_cnt != exp_ill) begin
        errors++;
        $display("FAIL rnd_count ret=%0d ill=%0d want %0d %0d",
                 ret_cnt, ill_cnt, exp_ret, exp_ill);
      end
      checks++;
      if (fetch_q.size() != exp_fetch.size()) begin
        errors++;
        $display("FAIL rnd_fetch_n n=%0d want %0d",
                 fetch_q.size(), exp_fetch.size());
      end else begin
        foreach (fetch_q[j]) begin
          checks++;
          if (fetch_q[j] != exp_fetch[j]) begin
            errors++;
            $display("FAIL rnd_fetch[%0d] addr=%h want %h",
                     j, fetch_q[j], exp_fetch[j]);
          end
        end
      end
      for (int i = 0; i < nr; i++) begin
        read_reg(i, v);
        checks++;
        if (v !== mregs[i]) begin
          errors++;
          $display("FAIL rnd_reg x%0d=%h want %h", i, v, mregs[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    bit got;
    sel = 1'b0;
    mem.delete();
    mem[0]  = enc_i(3'd0, 5'd1, 5'd0, 12'd9);
    last_pc = 32'd0;
    do_reset();
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (req_s === 1'b1) begin
        ack_v   = 1'b1;
        instr_v = mem[0];
        got     = 1;
      end
    end
    @(negedge clk);
    ack_v = 1'b0;
    rst_n = 1'b0;
    #1;
    read_reg(1, v);
    checks++;
    if (v !== 32'h0 || addr_s !== 32'h0 || req_s !== 1'b0) begin
      errors++;
      $display("FAIL rst_exec x1=%h pc=%h req=%b want 0 0 0",
               v, addr_s, req_s);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_q.delete();
    ret_cyc.delete();
    ret_cnt = 0;
    ill_cnt = 0;
    run_prog(0, 0);
    read_reg(1, v);
    checks++;
    if (v !== 32'd9 || ret_cnt != 1 ||
        fetch_q.size() != 1 || fetch_q[0] != 0) begin
      errors++;
      $display("FAIL rst_restart x1=%h ret=%0d want 9 1",
               v, ret_cnt);
    end
    do_reset();
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      ack_v = 1'b0;
      if (ret_s === 1'b1) got = 1;
      else if (req_s === 1'b1) begin
        ack_v   = 1'b1;
        instr_v = mem[0];
      end
    end
    ack_v = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    read_reg(1, v);
    checks++;
    if (v !== 32'h0 || !got || halt_s !== 1'b0) begin
      errors++;
      $display("FAIL rst_wb x1=%h wb=%b halt=%b want 0 1 0",
               v, got, halt_s);
    end
  endtask

  task automatic test_rv32e();
    logic [31:0] v1, v2;
    int unsigned ea [4];
    ea = '{0, 16, 32, 48};
    sel = 1'b1;
    mem.delete();
    mem[0]  = enc_i(3'd0, 5'd1, 5'd0, 12'd3);
    mem[16] = enc_i(3'd0, 5'd17, 5'd0, 12'd5);
    mem[32] = enc_r(7'h00, 3'd0, 5'd2, 5'd1, 5'd20);
    mem[48] = enc_i(3'd0, 5'd2, 5'd1, 12'd1);
    last_pc = 32'd48;
    do_reset();
    run_prog(1, 1);
    checks++;
    if (fetch_q.size() != 4) begin
      errors++;
      $display("FAIL e_fetch_n n=%0d want 4", fetch_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (fetch_q[i] != ea[i]) begin
          errors++;
          $display("FAIL e_fetch[%0d] addr=%h want %h",
                   i, fetch_q[i], ea[i]);
        end
      end
    end
    read_reg(1, v1);
    read_reg(2, v2);
    checks++;
    if (ill_cnt != 2 || v1 !== 32'd3 || v2 !== 32'd4) begin
      errors++;
      $display("FAIL e_ill ill=%0d x1=%h x2=%h want 2 3 4",
               ill_cnt, v1, v2);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_shift();
    test_slt();
    test_wait();
    test_illegal();
    test_random(1'b0, 8);
    test_reset_mid();
    test_rv32e();
    test_random(1'b1, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
